// File: rtl/dmem_latency_sized.sv
// Byte-addressed, little-endian data memory with configurable access latency.
// Supports byte/half/word (and dword when DATA_WIDTH=64) loads and stores,
// sign/zero extension of sub-word loads, and a Ready handshake so the CPU
// control FSM can stall. Misaligned requests only raise a one-cycle flag.
module dmem_latency_sized #(
    parameter int DATA_WIDTH     = 32,
    parameter int WORD_ADDR_BITS = 8,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int LATENCY        = 3
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [1:0]               Size,
    input  logic                     Unsigned,
    output logic [DATA_WIDTH-1:0]    MemData,
    output logic                     Ready,
    output logic                     Misaligned
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(NBYTES);
    localparam int DEPTH  = 1 << WORD_ADDR_BITS;
    localparam int CNT_W  = $clog2(LATENCY + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    // A request is misaligned when the offset is not a multiple of the access
    // size; a dword access on a 32-bit memory can never be honoured.
    function automatic logic is_misaligned(input logic [OFF-1:0] off,
                                           input logic [1:0]     sz);
        logic [OFF-1:0] mask;
        if (sz == 2'b11 && DATA_WIDTH == 32) begin
            return 1'b1;
        end
        mask = OFF'((1 << sz) - 1);
        return (off & mask) != '0;
    endfunction

    // Overlay the low bytes of the store data onto the addressed byte lanes.
    function automatic logic [DATA_WIDTH-1:0] merge_store(input logic [DATA_WIDTH-1:0] old,
                                                          input logic [DATA_WIDTH-1:0] wd,
                                                          input logic [OFF-1:0]        off,
                                                          input logic [1:0]            sz);
        logic [DATA_WIDTH-1:0] res;
        int nb;
        int o;
        res = old;
        nb  = 1 << sz;
        o   = int'(off);
        for (int i = 0; i < NBYTES; i++) begin
            if (i >= o && i < o + nb) begin
                res[8*i +: 8] = wd[8*(i-o) +: 8];
            end
        end
        return res;
    endfunction

    // Shift the addressed bytes down and sign- or zero-extend to full width.
    function automatic logic [DATA_WIDTH-1:0] extend_load(input logic [DATA_WIDTH-1:0] word,
                                                          input logic [OFF-1:0]        off,
                                                          input logic [1:0]            sz,
                                                          input logic                  uns);
        logic [DATA_WIDTH-1:0] sh;
        logic [DATA_WIDTH-1:0] res;
        logic                  sgn;
        int nbits;
        sh    = word >> (8 * int'(off));
        nbits = 8 << sz;
        sgn   = 1'b0;
        res   = sh;
        if (nbits < DATA_WIDTH) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (i == nbits - 1) begin
                    sgn = ~uns & sh[i];
                end
            end
            for (int i = 0; i < DATA_WIDTH; i++) begin
                res[i] = (i < nbits) ? sh[i] : sgn;
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0]     mem [0:DEPTH-1];
    logic [0:0]                state;
    logic [CNT_W-1:0]          cnt;

    logic [OFF-1:0]            req_off;
    logic [WORD_ADDR_BITS-1:0] req_idx;
    logic                      accept;
    logic                      req_mis;
    logic                      go;

    logic [OFF-1:0]            off_p0;
    logic [WORD_ADDR_BITS-1:0] idx_p0;
    logic [DATA_WIDTH-1:0]     wdata_p0;
    logic [1:0]                size_p0;
    logic                      uns_p0;
    logic                      wr_p0;

    logic                      c_fire;
    logic [OFF-1:0]            c_off;
    logic [WORD_ADDR_BITS-1:0] c_idx;
    logic [DATA_WIDTH-1:0]     c_wd;
    logic [1:0]                c_sz;
    logic                      c_uns;
    logic                      c_wr;

    // Address bits above the memory size alias and are intentionally dropped.
    generate
        if (ADDRESS_WIDTH > OFF + WORD_ADDR_BITS) begin : g_alias
            logic unused_high_addr;
            assign unused_high_addr = ^Address[ADDRESS_WIDTH-1:OFF+WORD_ADDR_BITS];
        end
    endgenerate

    assign req_off = Address[OFF-1:0];
    assign req_idx = Address[OFF+WORD_ADDR_BITS-1:OFF];
    assign Ready   = (state == S_IDLE);
    assign accept  = Ready && (MemRead || MemWrite);
    assign req_mis = is_misaligned(req_off, Size);
    assign go      = accept && !req_mis;

    // Completion source: live inputs for single-cycle memory, captured request otherwise.
    always_comb begin
        c_fire = 1'b0;
        c_off  = off_p0;
        c_idx  = idx_p0;
        c_wd   = wdata_p0;
        c_sz   = size_p0;
        c_uns  = uns_p0;
        c_wr   = wr_p0;
        if (LATENCY == 1) begin
            c_fire = go;
            c_off  = req_off;
            c_idx  = req_idx;
            c_wd   = WriteData;
            c_sz   = Size;
            c_uns  = Unsigned;
            c_wr   = MemWrite;
        end else begin
            c_fire = (state == S_BUSY) && (cnt == CNT_W'(1));
        end
    end

    // Control FSM: latency counter, busy state and misalignment pulse.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            Misaligned <= 1'b0;
        end else begin
            Misaligned <= accept && req_mis;
            case (state)
                S_IDLE: begin
                    if (go && LATENCY > 1) begin
                        state <= S_BUSY;
                        cnt   <= CNT_W'(LATENCY - 1);
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Request capture stage: hold the accepted request while the access is in flight.
    always_ff @(posedge Clk) begin
        if (go) begin
            off_p0   <= req_off;
            idx_p0   <= req_idx;
            wdata_p0 <= WriteData;
            size_p0  <= Size;
            uns_p0   <= Unsigned;
            wr_p0    <= MemWrite;
        end
    end

    // Store completion: write only the selected lanes; a reset discards the pending store.
    always_ff @(posedge Clk) begin
        if (!Reset && c_fire && c_wr) begin
            mem[c_idx] <= merge_store(mem[c_idx], c_wd, c_off, c_sz);
        end
    end

    // Load completion: register the extended result and hold it until the next load.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            MemData <= '0;
        end else if (c_fire && !c_wr) begin
            MemData <= extend_load(mem[c_idx], c_off, c_sz, c_uns);
        end
    end

endmodule

// File: tb/tb_dmem_latency_sized.sv
// Directed bench for dmem_latency_sized (defaults: 32-bit, 256 words, LATENCY=3).
// Expected load results come from a byte-array reference model and are queued
// when a load is issued, then popped when the memory signals completion.
module tb_dmem_latency_sized;

    logic        Clk;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  Size;
    logic        Unsigned;
    logic [31:0] MemData;
    logic        Ready;
    logic        Misaligned;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mref [0:1023];
    logic [31:0] sb [$];
    logic [31:0] exp_md;

    dmem_latency_sized dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Size      (Size),
        .Unsigned  (Unsigned),
        .MemData   (MemData),
        .Ready     (Ready),
        .Misaligned(Misaligned)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] v;
        int n;
        int b;
        n = 1 << sz;
        b = int'(a[9:0]);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mref[(b + i) % 1024];
        if (!uns) begin
            for (int i = 8 * n; i < 32; i++) v[i] = v[8*n-1];
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int n;
        int b;
        n = 1 << sz;
        b = int'(a[9:0]);
        for (int i = 0; i < n; i++) mref[(b + i) % 1024] = wd[8*i +: 8];
    endtask

    // One request: drive at negedge, accept at posedge, follow it to completion.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                          input logic wr, input logic [1:0] sz, input logic uns,
                          input bit mis, input string tag);
        int cyc;
        bit is_load;
        is_load = rd && !wr;
        @(negedge Clk);
        Address   = a;
        WriteData = wd;
        MemRead   = rd;
        MemWrite  = wr;
        Size      = sz;
        Unsigned  = uns;
        if (!mis && is_load) sb.push_back(model_load(a, sz, uns));
        if (!mis && wr) model_store(a, wd, sz);
        @(posedge Clk);
        #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        if (mis) begin
            check({tag, "_mis_pulse"}, 64'(Misaligned), 64'd1);
            check({tag, "_mis_ready"}, 64'(Ready), 64'd1);
            check({tag, "_mis_data"}, 64'(MemData), 64'(exp_md));
            @(posedge Clk);
            #1;
            check({tag, "_mis_clear"}, 64'(Misaligned), 64'd0);
        end else begin
            check({tag, "_busy"}, 64'(Ready), 64'd0);
            cyc = 1;
            while (!Ready && cyc < 20) begin
                @(posedge Clk);
                #1;
                cyc++;
            end
            check({tag, "_latency"}, 64'(cyc), 64'd3);
            check({tag, "_no_mis"}, 64'(Misaligned), 64'd0);
            if (is_load) begin
                if (sb.size() == 0) begin
                    check({tag, "_sb_empty"}, 64'd0, 64'd1);
                end else begin
                    exp_md = sb.pop_front();
                end
            end
            check({tag, "_data"}, 64'(MemData), 64'(exp_md));
        end
    endtask

    initial begin
        Reset     = 1'b1;
        Address   = '0;
        WriteData = '0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        Size      = 2'b00;
        Unsigned  = 1'b0;
        exp_md    = '0;

        repeat (2) @(posedge Clk);
        #1;
        check("rst_ready", 64'(Ready), 64'd1);
        check("rst_memdata", 64'(MemData), 64'd0);
        check("rst_mis", 64'(Misaligned), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;

        // Word store then word load
        access(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, "st_w10");
        access(32'h10, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "ld_w10");

        // Sub-word loads with extension
        access(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, "ld_b13_s");
        access(32'h13, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, "ld_b13_u");
        access(32'h10, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, "ld_h10_s");
        access(32'h12, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, "ld_h12_u");

        // Byte store keeps neighbouring bytes
        access(32'h11, 32'hAABBCC55, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, "st_b11");
        access(32'h10, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "ld_w10_b");

        // Misaligned requests: no effect
        access(32'h11, 32'h0,        1'b1, 1'b0, 2'b01, 1'b0, 1'b1, "mis_ld_h11");
        access(32'h12, 32'h01020304, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, "mis_st_w12");
        access(32'h10, 32'h0,        1'b1, 1'b0, 2'b11, 1'b0, 1'b1, "mis_dword");
        access(32'h10, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "ld_w10_m");

        // Aliasing and read/write priority
        access(32'h400, 32'h12345678, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, "st_w400");
        access(32'h000, 32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "ld_w000");
        access(32'h10,  32'hA5C3E1F0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, "rw_both");
        access(32'h10,  32'h0,        1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "ld_w10_rw");

        // Reset while a store is in flight
        access(32'h20, 32'h11111111, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, "st_w20");
        @(negedge Clk);
        Address   = 32'h20;
        WriteData = 32'hCAFEF00D;
        MemWrite  = 1'b1;
        Size      = 2'b10;
        @(posedge Clk);
        #1;
        MemWrite = 1'b0;
        check("rstmid_busy", 64'(Ready), 64'd0);
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1;
        exp_md = '0;
        check("rstmid_ready", 64'(Ready), 64'd1);
        check("rstmid_memdata", 64'(MemData), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        access(32'h20, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, "ld_w20");

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
